fetch_issue_buffer: RTL and testbench

//  Fetch-side producer of the FE->ID interface. Issues in-order 32-bit instruction fetch requests,

---
 rtl/fetch_issue_buffer.sv | 124 ++++++++++++
 tb/tb_fetch_issue_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_issue_buffer.sv
// Fetch-side producer of the FE->ID interface: issues in-order fetch requests
// under a credit limit, buffers responses in a small FIFO and drives the
// registered FEID payload. Responses in flight at a flush are discarded.
module fetch_issue_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned MAXOUT = 2
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_flush_i,
    input  logic        s_stall_i,
    output logic        s_req_o,
    input  logic        s_gnt_i,
    input  logic        s_rsp_valid_i,
    input  logic [31:0] s_rsp_data_i,
    input  logic [1:0]  s_rsp_err_i,
    input  logic [1:0]  s_rsp_pred_i,
    output logic [4:0]  s_feid_info_o,
    output logic [31:0] s_feid_instr_o,
    output logic [1:0]  s_feid_pred_o,
    output logic        s_empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAXOUT + 1);

    typedef enum logic {
        ST_RUN,
        ST_DISCARD
    } state_t;

    state_t        state;
    logic [35:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [OW-1:0] outst;
    logic [OW-1:0] discard;
    logic          ffa;

    logic          issue;
    logic          rsp_acc;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_sum;
    logic [OW-1:0] outst_after_rsp;
    logic [35:0]   head;

    // Request credit, response acceptance and FIFO push/pop decisions
    always_comb begin
        credit_sum      = (CW+1)'(count) + (CW+1)'(outst);
        s_req_o         = !s_reset_i && (state == ST_RUN) && !s_flush_i &&
                          (outst < OW'(MAXOUT)) && (credit_sum < (CW+1)'(DEPTH));
        issue           = s_req_o && s_gnt_i;
        rsp_acc         = s_rsp_valid_i && (outst != '0);
        outst_after_rsp = outst - OW'(rsp_acc);
        push            = rsp_acc && (state == ST_RUN) && !s_flush_i;
        pop             = !s_flush_i && !s_stall_i && (count != '0);
        head            = mem[rd_ptr];
        s_empty_o       = (count == '0) && (outst == '0);
    end

    // FIFO storage; contents are only meaningful below count, so no reset
    always_ff @(posedge s_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {s_rsp_data_i, s_rsp_err_i, s_rsp_pred_i};
        end
    end

    // Control state, FIFO pointers and the registered FEID payload
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            state          <= ST_RUN;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            outst          <= '0;
            discard        <= '0;
            ffa            <= 1'b1;
            s_feid_info_o  <= '0;
            s_feid_instr_o <= '0;
            s_feid_pred_o  <= '0;
        end else begin
            outst <= outst + OW'(issue) - OW'(rsp_acc);
            if (s_flush_i) begin
                // Any response arriving in the flush cycle is already retired
                // from outstanding and dropped, so it is not counted for discard.
                rd_ptr        <= '0;
                wr_ptr        <= '0;
                count         <= '0;
                ffa           <= 1'b1;
                s_feid_info_o <= '0;
                discard       <= outst_after_rsp;
                state         <= (outst_after_rsp != '0) ? ST_DISCARD : ST_RUN;
            end else begin
                if ((state == ST_DISCARD) && rsp_acc) begin
                    discard <= discard - OW'(1);
                    if (discard == OW'(1)) begin
                        state <= ST_RUN;
                    end
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
                if (!s_stall_i) begin
                    if (count != '0) begin
                        s_feid_info_o  <= {1'b0, ffa, head[3:2], 1'b1};
                        s_feid_instr_o <= head[35:4];
                        s_feid_pred_o  <= head[1:0];
                        ffa            <= 1'b0;
                    end else begin
                        s_feid_info_o <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_issue_buffer.sv
// Directed bench for fetch_issue_buffer: steady streaming, stall backpressure,
// flush with discard, flush during stall, error words and mid-run reset.
module tb_fetch_issue_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stall;
    logic        req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  rerr;
    logic [1:0]  rpred;
    logic [4:0]  info;
    logic [31:0] instr;
    logic [1:0]  pred;
    logic        empty;

    int total = 0;
    int bad   = 0;

    fetch_issue_buffer #(.DEPTH(4), .MAXOUT(2)) dut (
        .s_clk_i        (clk),
        .s_reset_i      (rst),
        .s_flush_i      (flush),
        .s_stall_i      (stall),
        .s_req_o        (req),
        .s_gnt_i        (gnt),
        .s_rsp_valid_i  (rv),
        .s_rsp_data_i   (rdata),
        .s_rsp_err_i    (rerr),
        .s_rsp_pred_i   (rpred),
        .s_feid_info_o  (info),
        .s_feid_instr_o (instr),
        .s_feid_pred_o  (pred),
        .s_empty_o      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dw(input int k);
        logic [31:0] base;
        base = 32'h1000_0000;
        return base + 32'(k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic st, input logic g, input logic v,
                         input logic [31:0] d, input logic [1:0] e, input logic [1:0] p);
        flush = fl;
        stall = st;
        gnt   = g;
        rv    = v;
        rdata = d;
        rerr  = e;
        rpred = p;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, '0, '0, '0);
        #1;
        chk("req_in_reset", 32'(req), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_info", 32'(info), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pred", 32'(pred), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_req", 32'(req), 32'd1);

        // Streaming: grant every cycle, responses one cycle after grant
        drive(0, 0, 1, 0, '0, '0, '0);          chk("a1_req", 32'(req), 32'd1); tick();
        drive(0, 0, 1, 1, dw(0), '0, '0);       chk("a2_req", 32'(req), 32'd1); tick();
        chk("a3_latency_info", 32'(info), 32'd0);
        drive(0, 0, 1, 1, dw(1), '0, '0);       tick();
        chk("a4_first_info", 32'(info), 32'b01001);
        chk("a4_instr", instr, dw(0));
        drive(0, 0, 1, 1, dw(2), '0, '0);       tick();
        chk("a5_info", 32'(info), 32'b00001);
        chk("a5_instr", instr, dw(1));

        // Stall for six cycles with responses continuing until credit runs out
        drive(0, 1, 1, 1, dw(3), '0, '0);       chk("a5_req", 32'(req), 32'd1); tick();
        drive(0, 1, 1, 1, dw(4), '0, '0);       chk("a6_req", 32'(req), 32'd1); tick();
        drive(0, 1, 1, 1, dw(5), '0, '0);       chk("a7_req_credit", 32'(req), 32'd0); tick();
        drive(0, 1, 1, 0, '0, '0, '0);          chk("a8_req_full", 32'(req), 32'd0); tick();
        drive(0, 1, 1, 0, '0, '0, '0);          tick();
        chk("a10_info_hold", 32'(info), 32'b00001);
        chk("a10_instr_hold", instr, dw(1));
        chk("a10_not_empty", 32'(empty), 32'd0);
        drive(0, 1, 1, 0, '0, '0, '0);          tick();
        drive(0, 0, 1, 0, '0, '0, '0);          chk("a11_req_full", 32'(req), 32'd0); tick();
        chk("a12_instr", instr, dw(2));
        chk("a12_info", 32'(info), 32'b00001);
        drive(0, 0, 1, 0, '0, '0, '0);          chk("a12_req", 32'(req), 32'd1); tick();
        chk("a13_instr", instr, dw(3));
        drive(0, 0, 1, 1, dw(6), '0, '0);       tick();
        chk("a14_instr", instr, dw(4));
        drive(0, 0, 0, 1, dw(7), '0, '0);       tick();
        chk("a15_instr", instr, dw(5));
        drive(0, 0, 0, 0, '0, '0, '0);          tick();
        chk("a16_instr", instr, dw(6));
        tick();
        chk("a17_instr", instr, dw(7));
        chk("a17_info", 32'(info), 32'b00001);
        tick();
        chk("a18_bubble", 32'(info), 32'd0);
        chk("a18_instr_hold", instr, dw(7));
        chk("a18_empty", 32'(empty), 32'd1);

        // Flush with two requests outstanding
        drive(0, 0, 1, 0, '0, '0, '0);          chk("b1_req", 32'(req), 32'd1); tick();
        drive(0, 0, 1, 0, '0, '0, '0);          chk("b2_req", 32'(req), 32'd1); tick();
        drive(0, 0, 1, 0, '0, '0, '0);          chk("b3_req_maxout", 32'(req), 32'd0); tick();
        drive(1, 0, 1, 0, '0, '0, '0);          chk("b4_req_flush", 32'(req), 32'd0); tick();
        chk("b5_info", 32'(info), 32'd0);
        drive(0, 0, 1, 1, dw(8), '0, '0);       chk("b5_req_discard", 32'(req), 32'd0); tick();
        drive(0, 0, 1, 1, dw(9), '0, '0);       chk("b6_req_discard", 32'(req), 32'd0); tick();
        chk("b7_empty", 32'(empty), 32'd1);
        drive(0, 0, 1, 0, '0, '0, '0);          chk("b7_req_run", 32'(req), 32'd1); tick();
        chk("b8_info", 32'(info), 32'd0);
        chk("b8_instr_hold", instr, dw(7));
        drive(0, 0, 0, 1, dw(10), '0, '0);      tick();
        chk("b9_no_dropped_word", 32'(info), 32'd0);
        drive(0, 0, 0, 0, '0, '0, '0);          tick();
        chk("b10_ffa_info", 32'(info), 32'b01001);
        chk("b10_instr", instr, dw(10));
        tick();
        chk("b11_info", 32'(info), 32'd0);
        chk("b11_empty", 32'(empty), 32'd1);

        // Flush coinciding with a response while stalled
        drive(0, 0, 1, 0, '0, '0, '0);          tick();
        drive(0, 0, 1, 1, dw(11), '0, '0);      tick();
        drive(0, 0, 1, 1, dw(12), '0, '0);      tick();
        chk("c4_info", 32'(info), 32'b00001);
        chk("c4_instr", instr, dw(11));
        drive(0, 1, 1, 0, '0, '0, '0);          chk("c4_req", 32'(req), 32'd1); tick();
        drive(1, 1, 1, 1, dw(13), '0, '0);      chk("c5_req_flush", 32'(req), 32'd0); tick();
        chk("c6_info_cleared", 32'(info), 32'd0);
        chk("c6_instr_hold", instr, dw(11));
        chk("c6_not_empty", 32'(empty), 32'd0);
        drive(0, 0, 1, 1, dw(14), '0, '0);      chk("c6_req_discard", 32'(req), 32'd0); tick();
        chk("c7_empty", 32'(empty), 32'd1);
        chk("c7_info", 32'(info), 32'd0);
        drive(0, 0, 1, 0, '0, '0, '0);          chk("c7_req_run", 32'(req), 32'd1); tick();

        // Corrected-error word follows an ordinary word
        drive(0, 0, 1, 1, dw(15), '0, '0);      tick();
        drive(0, 0, 0, 1, 32'h00A00513, 2'b10, 2'b11); tick();
        chk("c10_info", 32'(info), 32'b01001);
        chk("c10_instr", instr, dw(15));
        chk("c10_pred", 32'(pred), 32'd0);
        drive(0, 0, 0, 0, '0, '0, '0);          tick();
        chk("c11_err_info", 32'(info), 32'b00101);
        chk("c11_err_instr", instr, 32'h00A00513);
        chk("c11_err_pred", 32'(pred), 32'd3);
        tick();
        chk("c12_info", 32'(info), 32'd0);

        // Reset with three buffered words and one request outstanding
        drive(0, 1, 1, 0, '0, '0, '0);          tick();
        drive(0, 1, 1, 1, dw(20), '0, 2'b01);   tick();
        drive(0, 1, 1, 1, dw(21), '0, '0);      tick();
        drive(0, 0, 1, 1, dw(22), '0, '0);      tick();
        drive(0, 1, 1, 1, dw(23), '0, '0);      chk("d5_req", 32'(req), 32'd1); tick();
        chk("d6_info", 32'(info), 32'b00001);
        chk("d6_instr", instr, dw(20));
        chk("d6_pred", 32'(pred), 32'd1);
        drive(0, 0, 1, 0, '0, '0, '0);          chk("d6_req_full", 32'(req), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("d7_info", 32'(info), 32'd0);
        chk("d7_instr", instr, 32'd0);
        chk("d7_pred", 32'(pred), 32'd0);
        chk("d7_empty", 32'(empty), 32'd1);
        drive(0, 0, 0, 1, dw(24), '0, '0);      chk("d7_req", 32'(req), 32'd1); tick();
        chk("d8_late_rsp_empty", 32'(empty), 32'd1);
        chk("d8_info", 32'(info), 32'd0);
        drive(0, 0, 1, 0, '0, '0, '0);          tick();
        chk("d9_late_rsp_info", 32'(info), 32'd0);
        drive(0, 0, 0, 1, dw(25), '0, '0);      tick();
        drive(0, 0, 0, 0, '0, '0, '0);          tick();
        chk("d11_restart_info", 32'(info), 32'b01001);
        chk("d11_restart_instr", instr, dw(25));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
